// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared types and default parameters for the multiplier scheduler
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        RESP
    } state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 64;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr_i, wrapping
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o
);

    int j;

    // Walk from the farthest offset down to ptr_i so the nearest valid requester wins last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (en_i && req_i[j]) begin
                grant_o = NUM_REQ'(1) << j;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin sharing of one sequential multiplier among NUM_REQ requesters
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IW      = $clog2(NUM_REQ),
    localparam int WDW     = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IW-1:0]            rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     rsp_err,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    input  logic                     mul_ready,
    input  logic [2*WIDTH-1:0]       mul_product
);

    state_e             state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               err_q, err_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic               guard_q, guard_d;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gnt_idx;

    // Grants are only offered in IDLE and are suppressed while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .en_i    (state_q == IDLE && rst_n),
        .grant_o (grant),
        .idx_o   (gnt_idx)
    );

    // Next-state logic: grant, start pulse, completion/timeout wait, response handshake.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        err_d   = err_q;
        wd_d    = wd_q;
        guard_d = guard_q;
        case (state_q)
            IDLE: if (|grant) begin
                id_d    = gnt_idx;
                a_d     = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                b_d     = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                state_d = START;
            end
            START: begin
                wd_d    = '0;
                guard_d = 1'b0;
                state_d = BUSY;
            end
            BUSY: begin
                guard_d = 1'b1;
                if (guard_q && mul_ready) begin
                    prod_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            RESP: if (rsp_ready) begin
                rr_d    = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            guard_q <= guard_d;
        end
    end

    assign req_ready        = grant;
    assign rsp_valid        = state_q == RESP;
    assign rsp_id           = id_q;
    assign rsp_product      = prod_q;
    assign rsp_err          = err_q;
    assign mul_start        = state_q == START;
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;

endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
Shares one seq_multiplier instance between NUM_REQ requesters.
- Round-robin arbitration among pending requests.
- Sequences the multiplier: operand load, one-cycle start pulse, completion wait, product capture.
- Returns the result, tagged with the requester id, on a single response channel with backpressure.
- Sits between the requester-side blocks and the multiplier datapath.
- Contains a watchdog so that a hung multiplier cannot lock the shared resource.

Parameters:
- NUM_REQ, 4, number of requesters; must be 2 or more.
- WIDTH, 16, operand width; the product is 2*WIDTH bits, signed.
- TIMEOUT, 64, maximum number of BUSY cycles before an error response is issued.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*WIDTH  multiplicands, flattened; slice i belongs to requester i; signed.
- req_b  in  NUM_REQ*WIDTH  multipliers, flattened; signed.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NUM_REQ)  id of the requester that owns the response.
- rsp_product  out  2*WIDTH  signed product.
- rsp_err  out  1  set when the response is a timeout error.
- mul_start  out  1  start pulse to seq_multiplier.
- mul_multiplicand  out  WIDTH  operand to seq_multiplier.
- mul_multiplier  out  WIDTH  operand to seq_multiplier.
- mul_ready  in  1  seq_multiplier done flag.
- mul_product  in  2*WIDTH  seq_multiplier product.

Behaviour:
Reset:
- Every output is 0.
- State = IDLE, rr_ptr = 0, watchdog counter = 0.
- Reset is asynchronous and aborts any operation immediately. No response is issued for an aborted operation.

Requester rules:
- A requester holds req_valid and its operands stable until it sees req_ready.
- Requests are sampled only in IDLE.

FSM states: IDLE, START, BUSY, RESP.

IDLE:
- If any req_valid is high, grant g = the first valid index found searching upward from rr_ptr, wrapping modulo NUM_REQ.
- req_ready[g] = 1 for exactly this cycle.
- Latch the operands of g and the id g.
- Next state = START.

START:
- mul_start = 1 for exactly one cycle.
- Clear the watchdog and the guard bit.
- Next state = BUSY.

BUSY:
- The first BUSY cycle ignores mul_ready, because mul_ready may still be high from the previous operation.
- On any later cycle with mul_ready = 1: capture mul_product into rsp_product, set rsp_err = 0, go to RESP.
- If the watchdog reaches TIMEOUT first: rsp_product = 0, rsp_err = 1, go to RESP.

RESP:
- rsp_valid = 1. rsp_id, rsp_product and rsp_err are held stable.
- When rsp_valid and rsp_ready are both high: rr_ptr = (g+1) mod NUM_REQ, next state = IDLE, rsp_valid drops the next cycle.

Operand outputs:
- mul_multiplicand and mul_multiplier are registered.
- They are driven from the latch in START through RESP and are stable throughout the multiplication.

Latency:
- Accept at cycle T, mul_start at T+1.
- With seq_multiplier latency L (mul_ready first high L cycles after start), rsp_valid is at T+L+2.
- An idle-to-idle back-to-back request costs 1 extra cycle: no grant is made in the RESP-to-IDLE handshake cycle.

Boundary conditions:
- Requests arriving outside IDLE wait; they are never dropped.
- Only the granted requester sees req_ready.
- Multiple valids with rr_ptr pointing at an invalid index: search proceeds upward and wraps, e.g. ptr=3 with valids {0,2} grants 0.
- rsp_ready held low: the FSM stalls in RESP indefinitely and the multiplier stays idle.
- A mul_ready pulse while in IDLE, START or RESP is ignored.

Arithmetic:
- No arithmetic in this block; the product is passed through unmodified.
- The -2^(WIDTH-1) operand is legal.

Decomposition:
- Package mult_sched_pkg holds:
  - state enum typedef (IDLE, START, BUSY, RESP);
  - defaults for NUM_REQ, WIDTH and TIMEOUT;
  - id width derived with $clog2.
- Sub-module rr_arbiter(NUM_REQ): inputs req vector, ptr, enable; outputs one-hot grant and encoded index; purely combinational. The pointer register stays in mult_scheduler.
- The bench instantiates mult_scheduler connected to the real seq_multiplier.

Test Plan:
- Single request on requester 2: a=32767, b=-32768 -> req_ready[2] pulses once; rsp_id=2, rsp_product=-1073709056, rsp_err=0.
- All 4 requesters valid simultaneously, from reset, operands (i+1, -(i+1)) -> responses in id order 0,1,2,3 with products -1, -4, -9, -16; the second round starts at 0 again.
- Fairness: requester 0 always valid, requester 1 valid once -> order 0,1,0. Requester 1 is never starved.
- Backpressure: rsp_ready held low 20 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_product stay stable, and no new req_ready is issued. Releasing rsp_ready produces exactly one handshake.
- Timeout: the multiplier is stubbed with mul_ready tied low; request a=3, b=5 -> after TIMEOUT=64 BUSY cycles, rsp_valid=1, rsp_err=1, rsp_product=0; the next request completes normally.
- Reset mid-BUSY: rst_n low for 1 cycle during BUSY -> all outputs 0 asynchronously; no response for the aborted request; a re-issued request gives the correct product with rsp_id matching.
